// File: rtl/can_encoder.sv
// rtl/can_encoder.sv - CAN 2.0A/2.0B frame transmitter with CRC-15, bit stuffing and ACK check

module can_crc15 (
    input  logic [14:0] crc_in,
    input  logic        bit_in,
    output logic [14:0] crc_out
);
    logic nxt;

    assign nxt     = bit_in ^ crc_in[14];
    assign crc_out = {crc_in[13:0], 1'b0} ^ (nxt ? 15'h4599 : 15'h0000);
endmodule

module can_encoder #(
    parameter int EOF_BITS = 7,
    parameter int IFS_BITS = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_tick,
    input  logic        sample_point,
    input  logic        rx_bit,
    input  logic        tx_start,
    input  logic        in_ide,
    input  logic        in_rtr,
    input  logic [10:0] in_id_a,
    input  logic [17:0] in_id_b,
    input  logic [3:0]  in_dlc,
    input  logic [63:0] in_data,
    output logic        tx_bit,
    output logic        busy,
    output logic        done,
    output logic        ack_error
);
    typedef enum logic [3:0] {
        IDLE, WAIT_SOF, SOF, ARB, CTRL, DATA, CRC, CRC_DEL, ACK_SLOT, ACK_DEL, EOF, IFS
    } state_t;

    state_t      state, state_n;
    logic [5:0]  cnt, cnt_n, cnt_dec;
    logic        bit_n, crc_en, done_n, stuff_now, has_data;
    logic [2:0]  run;
    logic [14:0] crc, crc_nxt;
    logic        ide_r, rtr_r, ack_seen;
    logic [10:0] id_a_r;
    logic [17:0] id_b_r;
    logic [3:0]  dlc_r, n_bytes;
    logic [63:0] data_r;
    logic [31:0] arb_vec;
    logic [5:0]  ctrl_vec, arb_first, ctrl_first;
    logic [6:0]  data_stop;

    // State names the field whose bit is currently on the wire; cnt indexes that bit.
    assign arb_vec    = ide_r ? {id_a_r, 1'b1, 1'b1, id_b_r, rtr_r} : {19'd0, id_a_r, rtr_r, 1'b0};
    assign arb_first  = ide_r ? 6'd31 : 6'd12;
    assign ctrl_vec   = {2'b00, dlc_r};
    assign ctrl_first = ide_r ? 6'd5 : 6'd4;
    assign n_bytes    = rtr_r ? 4'd0 : ((dlc_r > 4'd8) ? 4'd8 : dlc_r);
    assign has_data   = (n_bytes != 4'd0);
    assign data_stop  = 7'd64 - {n_bytes, 3'b000};
    assign cnt_dec    = cnt - 6'd1;
    assign stuff_now  = (state inside {SOF, ARB, CTRL, DATA, CRC}) && (run == 3'd5);
    assign busy       = (state != IDLE);

    can_crc15 u_crc (
        .crc_in  (crc),
        .bit_in  (bit_n),
        .crc_out (crc_nxt)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = tx_bit;
        crc_en  = 1'b0;
        done_n  = 1'b0;
        if (state == IDLE) begin
            if (tx_start)
                state_n = WAIT_SOF;
        end else if (bit_tick) begin
            if (stuff_now) begin
                bit_n = ~tx_bit;
            end else begin
                case (state)
                    WAIT_SOF: begin
                        state_n = SOF;
                        bit_n   = 1'b0;
                        crc_en  = 1'b1;
                    end
                    SOF: begin
                        state_n = ARB;
                        cnt_n   = arb_first;
                        bit_n   = arb_vec[arb_first[4:0]];
                        crc_en  = 1'b1;
                    end
                    ARB: begin
                        crc_en = 1'b1;
                        if (cnt != 6'd0) begin
                            cnt_n = cnt_dec;
                            bit_n = arb_vec[cnt_dec[4:0]];
                        end else begin
                            state_n = CTRL;
                            cnt_n   = ctrl_first;
                            bit_n   = ctrl_vec[ctrl_first[2:0]];
                        end
                    end
                    CTRL: begin
                        if (cnt != 6'd0) begin
                            cnt_n  = cnt_dec;
                            bit_n  = ctrl_vec[cnt_dec[2:0]];
                            crc_en = 1'b1;
                        end else if (has_data) begin
                            state_n = DATA;
                            cnt_n   = 6'd63;
                            bit_n   = data_r[63];
                            crc_en  = 1'b1;
                        end else begin
                            state_n = CRC;
                            cnt_n   = 6'd14;
                            bit_n   = crc[14];
                        end
                    end
                    DATA: begin
                        if ({1'b0, cnt} != data_stop) begin
                            cnt_n  = cnt_dec;
                            bit_n  = data_r[cnt_dec];
                            crc_en = 1'b1;
                        end else begin
                            state_n = CRC;
                            cnt_n   = 6'd14;
                            bit_n   = crc[14];
                        end
                    end
                    CRC: begin
                        if (cnt != 6'd0) begin
                            cnt_n = cnt_dec;
                            bit_n = crc[cnt_dec[3:0]];
                        end else begin
                            state_n = CRC_DEL;
                            bit_n   = 1'b1;
                        end
                    end
                    CRC_DEL: begin
                        state_n = ACK_SLOT;
                        bit_n   = 1'b1;
                    end
                    ACK_SLOT: begin
                        state_n = ACK_DEL;
                        bit_n   = 1'b1;
                    end
                    ACK_DEL: begin
                        state_n = EOF;
                        cnt_n   = 6'(EOF_BITS - 1);
                        bit_n   = 1'b1;
                    end
                    EOF: begin
                        bit_n = 1'b1;
                        if (cnt != 6'd0) begin
                            cnt_n = cnt_dec;
                        end else begin
                            state_n = IFS;
                            cnt_n   = 6'(IFS_BITS - 1);
                        end
                    end
                    IFS: begin
                        bit_n = 1'b1;
                        if (cnt != 6'd0) begin
                            cnt_n = cnt_dec;
                        end else begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end
                    end
                    default: state_n = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 6'd0;
            tx_bit    <= 1'b1;
            done      <= 1'b0;
            ack_error <= 1'b0;
            ack_seen  <= 1'b0;
            crc       <= 15'd0;
            run       <= 3'd0;
            ide_r     <= 1'b0;
            rtr_r     <= 1'b0;
            id_a_r    <= 11'd0;
            id_b_r    <= 18'd0;
            dlc_r     <= 4'd0;
            data_r    <= 64'd0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            tx_bit <= bit_n;
            done   <= done_n;
            if (crc_en)
                crc <= crc_nxt;
            if (state == IDLE && tx_start) begin
                ide_r     <= in_ide;
                rtr_r     <= in_rtr;
                id_a_r    <= in_id_a;
                id_b_r    <= in_id_b;
                dlc_r     <= in_dlc;
                data_r    <= in_data;
                ack_error <= 1'b0;
                ack_seen  <= 1'b0;
                crc       <= 15'd0;
                run       <= 3'd0;
            end
            // Run length counts transmitted bits, stuff bits included.
            if (bit_tick && state != IDLE)
                run <= (bit_n == tx_bit) ? ((run == 3'd7) ? 3'd7 : run + 3'd1) : 3'd1;
            if (sample_point && state == ACK_SLOT)
                ack_seen <= ~rx_bit;
            if (done_n)
                ack_error <= ~ack_seen;
        end
    end
endmodule

// File: tb/tb_can_encoder.sv
// tb/tb_can_encoder.sv - scoreboard bench for can_encoder

module tb_can_encoder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        bit_tick = 1'b0;
    logic        sample_point = 1'b0;
    logic        rx_bit;
    logic        tx_start = 1'b0;
    logic        in_ide = 1'b0;
    logic        in_rtr = 1'b0;
    logic [10:0] in_id_a = 11'd0;
    logic [17:0] in_id_b = 18'd0;
    logic [3:0]  in_dlc = 4'd0;
    logic [63:0] in_data = 64'd0;
    logic        tx_bit, busy, done, ack_error;
    logic        force_ack = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          tick_phase = 0;
    logic        exp_q[$];

    assign rx_bit = force_ack ? 1'b0 : tx_bit;

    always #5 clk = ~clk;

    can_encoder #(.EOF_BITS(7), .IFS_BITS(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .bit_tick     (bit_tick),
        .sample_point (sample_point),
        .rx_bit       (rx_bit),
        .tx_start     (tx_start),
        .in_ide       (in_ide),
        .in_rtr       (in_rtr),
        .in_id_a      (in_id_a),
        .in_id_b      (in_id_b),
        .in_dlc       (in_dlc),
        .in_data      (in_data),
        .tx_bit       (tx_bit),
        .busy         (busy),
        .done         (done),
        .ack_error    (ack_error)
    );

    initial begin
        forever begin
            @(posedge clk);
            #2;
            tick_phase   = (tick_phase + 1) % 4;
            bit_tick     = (tick_phase == 0);
            sample_point = (tick_phase == 2);
        end
    end

    // Reference frame: unstuffed fields, CRC-15, stuffing, then the recessive tail.
    function automatic int build_frame(input logic ide, input logic rtr, input logic [10:0] id_a,
                                       input logic [17:0] id_b, input logic [3:0] dlc,
                                       input logic [63:0] data);
        logic        ub[$];
        logic [14:0] crc = 15'd0;
        logic        nb;
        logic        last = 1'b1;
        int          run = 0;
        int          nbytes;
        int          nst;
        exp_q.delete();
        ub.push_back(1'b0);
        for (int i = 10; i >= 0; i--) ub.push_back(id_a[i]);
        if (ide) begin
            ub.push_back(1'b1);
            ub.push_back(1'b1);
            for (int i = 17; i >= 0; i--) ub.push_back(id_b[i]);
            ub.push_back(rtr);
            ub.push_back(1'b0);
            ub.push_back(1'b0);
        end else begin
            ub.push_back(rtr);
            ub.push_back(1'b0);
            ub.push_back(1'b0);
        end
        for (int i = 3; i >= 0; i--) ub.push_back(dlc[i]);
        nbytes = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
        for (int i = 0; i < nbytes * 8; i++) ub.push_back(data[63 - i]);
        foreach (ub[i]) begin
            nb  = ub[i] ^ crc[14];
            crc = {crc[13:0], 1'b0};
            if (nb) crc = crc ^ 15'h4599;
        end
        for (int i = 14; i >= 0; i--) ub.push_back(crc[i]);
        foreach (ub[i]) begin
            exp_q.push_back(ub[i]);
            run  = (ub[i] == last) ? run + 1 : 1;
            last = ub[i];
            if (run == 5) begin
                exp_q.push_back(~last);
                last = ~last;
                run  = 1;
            end
        end
        nst = exp_q.size();
        for (int i = 0; i < 13; i++) exp_q.push_back(1'b1);
        return nst;
    endfunction

    task automatic start_tx(input logic ide, input logic rtr, input logic [10:0] id_a,
                            input logic [17:0] id_b, input logic [3:0] dlc, input logic [63:0] data);
        @(negedge clk);
        while (bit_tick) @(negedge clk);
        in_ide   = ide;
        in_rtr   = rtr;
        in_id_a  = id_a;
        in_id_b  = id_b;
        in_dlc   = dlc;
        in_data  = data;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic run_frame(input string name, input logic ide, input logic rtr,
                             input logic [10:0] id_a, input logic [17:0] id_b, input logic [3:0] dlc,
                             input logic [63:0] data, input logic ack_drive, input int exp_ticks,
                             input logic poke);
        int   nst, total, idx, ticks, cyc, dones, run, want_ticks;
        logic prev_tick, last_bit, cur_bit, got_done, eb;
        nst        = build_frame(ide, rtr, id_a, id_b, dlc, data);
        total      = exp_q.size();
        want_ticks = (exp_ticks > 0) ? exp_ticks : total;
        start_tx(ide, rtr, id_a, id_b, dlc, data);
        n_checks++;
        if (busy !== 1'b1 || ack_error !== 1'b0 || tx_bit !== 1'b1) begin
            n_fail++;
            $display("FAIL %s start: busy=%b ack_error=%b tx_bit=%b, required 1/0/1", name, busy, ack_error, tx_bit);
        end
        prev_tick = bit_tick;
        idx = 0; ticks = 0; cyc = 0; dones = 0; run = 0;
        last_bit = 1'b1; cur_bit = 1'b1; got_done = 1'b0;
        while (!got_done && cyc < (total + 4) * 8) begin
            @(negedge clk);
            cyc++;
            if (tx_start) tx_start = 1'b0;
            if (done) dones++;
            if (prev_tick) begin
                force_ack = 1'b0;
                if (idx > 0) ticks++;
                if (idx < total) begin
                    eb = exp_q.pop_front();
                    n_checks++;
                    if (tx_bit !== eb || done !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s bit %0d: tx_bit=%b done=%b, required %b/0", name, idx, tx_bit, done, eb);
                    end
                    cur_bit = eb;
                    if (idx < nst) begin
                        run      = (tx_bit === last_bit) ? run + 1 : 1;
                        last_bit = tx_bit;
                        n_checks++;
                        if (run > 5) begin
                            n_fail++;
                            $display("FAIL %s run at bit %0d: run=%0d, required <=5", name, idx, run);
                        end
                    end
                    if (idx == nst + 1 && ack_drive) force_ack = 1'b1;
                    if (poke && idx == 10) begin
                        in_id_a  = ~id_a;
                        in_ide   = ~ide;
                        in_data  = ~data;
                        tx_start = 1'b1;
                    end
                    idx++;
                end else begin
                    got_done = 1'b1;
                    n_checks++;
                    if (done !== 1'b1 || busy !== 1'b0 || ack_error !== ~ack_drive || ticks != want_ticks) begin
                        n_fail++;
                        $display("FAIL %s end: done=%b busy=%b ack_error=%b ticks=%0d, required 1/0/%b/%0d",
                                 name, done, busy, ack_error, ticks, ~ack_drive, want_ticks);
                    end
                end
            end else if (idx > 0) begin
                n_checks++;
                if (tx_bit !== cur_bit) begin
                    n_fail++;
                    $display("FAIL %s hold after bit %0d: tx_bit=%b, required %b", name, idx - 1, tx_bit, cur_bit);
                end
            end
            prev_tick = bit_tick;
            if (poke && !got_done && idx == total && bit_tick) tx_start = 1'b1;
        end
        tx_start  = 1'b0;
        force_ack = 1'b0;
        if (!got_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: bits=%0d, required %0d then done", name, idx, total);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || dones != 1) begin
            n_fail++;
            $display("FAIL %s after: done=%b busy=%b pulses=%0d, required 0/0/1", name, done, busy, dones);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (tx_bit !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || ack_error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: tx_bit=%b busy=%b done=%b ack_error=%b, required 1/0/0/0", tx_bit, busy, done, ack_error);
        end
        rst = 1'b1;
    endtask

    task automatic test_std_zero();
        run_frame("std_zero", 1'b0, 1'b0, 11'h000, 18'h0, 4'd0, 64'h0, 1'b0, 53, 1'b0);
    endtask

    task automatic test_ack();
        run_frame("ack_seen", 1'b0, 1'b0, 11'h000, 18'h0, 4'd0, 64'h0, 1'b1, 53, 1'b0);
    endtask

    task automatic test_data_frames();
        run_frame("std_123", 1'b0, 1'b0, 11'h123, 18'h0, 4'd2, 64'hA55A_0000_0000_0000, 1'b1, 0, 1'b0);
        run_frame("ext_max", 1'b1, 1'b0, 11'h7FF, 18'h3FFFF, 4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0, 1'b0);
        run_frame("ext_mix", 1'b1, 1'b0, 11'h2A5, 18'h0F0F3, 4'd5, 64'h0123_4567_89AB_CDEF, 1'b0, 0, 1'b0);
        run_frame("dlc_12", 1'b0, 1'b0, 11'h40F, 18'h0, 4'd12, 64'h8000_0001_FF00_00FF, 1'b1, 0, 1'b0);
    endtask

    task automatic test_remote();
        run_frame("remote", 1'b0, 1'b1, 11'h055, 18'h0, 4'd8, 64'hDEAD_BEEF_0BAD_F00D, 1'b1, 0, 1'b0);
        run_frame("remote_ext", 1'b1, 1'b1, 11'h3C3, 18'h15555, 4'd8, 64'hFFFF_0000_FFFF_0000, 1'b1, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_frame("busy_start", 1'b0, 1'b0, 11'h1F0, 18'h0, 4'd3, 64'h00FF_AA00_0000_0000, 1'b1, 0, 1'b1);
        run_frame("next_frame", 1'b0, 1'b0, 11'h001, 18'h0, 4'd1, 64'h7E00_0000_0000_0000, 1'b1, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        start_tx(1'b0, 1'b0, 11'h123, 18'h0, 4'd2, 64'hA55A_0000_0000_0000);
        repeat (90) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy: busy=%b, required 1", busy);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n_checks++;
        if (tx_bit !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: tx_bit=%b busy=%b done=%b, required 1/0/0", tx_bit, busy, done);
        end
        run_frame("post_reset", 1'b0, 1'b0, 11'h123, 18'h0, 4'd2, 64'hA55A_0000_0000_0000, 1'b1, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_std_zero();
        test_ack();
        test_data_frames();
        test_remote();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
